// File: rtl/md_if.sv
// rtl/md_if.sv - multiply/divide unit E-stage request and HI/LO result bundle
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             md_use_d;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             md_stall;

  // pipeline side: issues md ops and reads HI/LO
  modport master (
    output start, md_op, a, b, md_use_d,
    input  busy, hi, lo, md_stall
  );

  // unit side
  modport slave (
    input  start, md_op, a, b, md_use_d,
    output busy, hi, lo, md_stall
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  md_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [2*WIDTH-1:0]        prod_u;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quo_u;
  logic [WIDTH-1:0]          rem_u;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          res_hi;
  logic [WIDTH-1:0]          res_lo;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Result is formed from the captured operands only, so HI/LO never see a/b combinationally.
  always_comb begin
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    div_zero = (b_q == '0);
    div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
    quo_s    = '0;
    rem_s    = '0;
    quo_u    = '0;
    rem_u    = '0;
    // Guard the operators so divide-by-zero and the signed overflow case never reach them.
    if (!div_zero && !div_ovf) begin
      quo_s = $signed(a_q) / $signed(b_q);
      rem_s = $signed(a_q) % $signed(b_q);
    end
    if (!div_zero) begin
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
    end
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'd0: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      2'd1: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      2'd2: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a_q;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      default: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
    endcase
  end

  // Control FSM: IDLE accepts ops, BUSY counts down and lands the result on the last edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              3'd0, 3'd1: begin
                op_q   <= bus.md_op[1:0];
                a_q    <= bus.a;
                b_q    <= bus.b;
                cnt    <= CW'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= BUSY;
              end
              3'd2, 3'd3: begin
                op_q   <= bus.md_op[1:0];
                a_q    <= bus.a;
                b_q    <= bus.b;
                cnt    <= CW'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= BUSY;
              end
              3'd4: hi_q <= bus.a;
              3'd5: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // Any start arriving here is dropped; the decode stall should keep it from happening.
          if (cnt == CW'(1)) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = bus.md_use_d & (busy_q | (bus.start & (bus.md_op <= 3'd3)));

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit
module tb_md_unit;

  localparam int WIDTH       = 32;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_if #(.WIDTH(WIDTH)) bus ();

  md_unit #(
    .WIDTH(WIDTH),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference {hi,lo} from the arithmetic rules, using 64-bit integers and magnitudes.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint          sa, sb, ma, mb, q, r, p;
    longint unsigned ua, ub, up;
    logic [63:0]     res;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    res = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; res = p; end
      3'd1: begin up = ua * ub; res = up; end
      3'd2: begin
        if (bv == 32'd0) res = {av, 32'hFFFFFFFF};
        else if (av == 32'h80000000 && bv == 32'hFFFFFFFF) res = {32'd0, av};
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ma / mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          r  = sa - q * sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (bv == 32'd0) res = {av, 32'hFFFFFFFF};
        else begin
          up = ua / ub;
          res[31:0] = up[31:0];
          up = ua % ub;
          res[63:32] = up[31:0];
        end
      end
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  // Issue one op at edge+1 and follow it through the busy window to the HI/LO update.
  task automatic run_md(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic use_d, input bit poke);
    logic [63:0] r;
    int          n;
    bus.start    = 1'b1;
    bus.md_op    = op;
    bus.a        = av;
    bus.b        = bv;
    bus.md_use_d = use_d;
    #1;
    check("stall_start", bus.md_stall, use_d && (op <= 3'd3));
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op <= 3'd3) begin
      r = model(op, av, bv);
      n = (op < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
      for (int i = 0; i < n; i++) begin
        if (poke && i == 1) begin
          bus.start = 1'b1;
          bus.md_op = 3'd5;
          bus.a     = $urandom;
        end
        #1;
        check("busy_hold", bus.busy, 1'b1);
        check("stall_busy", bus.md_stall, use_d);
        check("hi_hold", bus.hi, exp_hi);
        check("lo_hold", bus.lo, exp_lo);
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check("busy_fall", bus.busy, 1'b0);
      check("stall_fall", bus.md_stall, 1'b0);
    end else begin
      if (op == 3'd4) exp_hi = av;
      if (op == 3'd5) exp_lo = av;
      check("busy_idle", bus.busy, 1'b0);
    end
    check("hi", bus.hi, exp_hi);
    check("lo", bus.lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] av, bv;
    n_tests      = 0;
    n_fail       = 0;
    exp_hi       = '0;
    exp_lo       = '0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.md_op    = 3'd6;
    bus.a        = '0;
    bus.b        = '0;
    bus.md_use_d = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 1'b0);
    check("idle_hi", bus.hi, 32'd0);
    check("idle_lo", bus.lo, 32'd0);

    run_md(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    check("mult_hi_const", bus.hi, 32'hFFFFFFFF);
    check("mult_lo_const", bus.lo, 32'hFFFFFFFA);
    run_md(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    check("multu_hi_const", bus.hi, 32'd2);
    check("multu_lo_const", bus.lo, 32'hFFFFFFFA);
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    check("div_lo_const", bus.lo, 32'hFFFFFFFD);
    check("div_hi_const", bus.hi, 32'hFFFFFFFF);
    run_md(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lo_const", bus.lo, 32'd3);
    check("divu_hi_const", bus.hi, 32'd1);
    run_md(3'd2, 32'd5, 32'd0, 1'b1, 1'b0);
    check("div0_lo_const", bus.lo, 32'hFFFFFFFF);
    check("div0_hi_const", bus.hi, 32'd5);
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("ovf_lo_const", bus.lo, 32'h80000000);
    check("ovf_hi_const", bus.hi, 32'd0);
    run_md(3'd0, 32'd1000, 32'd7, 1'b1, 1'b1);
    check("poke_lo_const", bus.lo, 32'd7000);
    run_md(3'd4, 32'h1234, 32'd0, 1'b1, 1'b0);
    check("mthi_const", bus.hi, 32'h1234);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'd0;
        1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        2: bv = 32'($urandom_range(1, 9));
        3: bv = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_md(op, av, bv, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Abort a divide with an asynchronous reset partway through.
    bus.start    = 1'b1;
    bus.md_op    = 3'd2;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    bus.md_use_d = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    #2;
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (DIV_CYCLES + 2) @(posedge clk);
    #1;
    check("post_abort_busy", bus.busy, 1'b0);
    check("post_abort_hi", bus.hi, 32'd0);
    check("post_abort_lo", bus.lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the execute stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and holds busy for a parametrised number of cycles.
- Produces a decode-stage stall request when a HI/LO-using instruction (mfhi/mflo/any md op) sits in D while the unit is busy or starting.
- Successor to the single-cycle ALU path: width and latencies are parametrised, and it adds sequential busy/stall behaviour.

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage md instruction valid this cycle
- md_op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op
- a  input  WIDTH  forwarded rs value
- b  input  WIDTH  forwarded rt value
- md_use_d  input  1  D-stage instruction reads/writes HI/LO
- busy  output  1  multi-cycle operation in progress
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- md_stall  output  1  stall request to D (combinational)

Behaviour:
- Reset (reset=0, async): state IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared. Reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE and BUSY.
- IDLE, start=1, op in {0..3}:
  - Capture operands.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY at the next edge.
- IDLE, start=1, op 4/5: hi (or lo) <= a at the edge. No busy.
- IDLE, start=1, op 6/7: no effect.
- Latency: start sampled at edge E0 → busy=1 for exactly N cycles after E0 → HI/LO written at edge E0+N, at which point busy returns 0. New HI/LO are visible the same cycle busy falls.
- BUSY: counter decrements each edge. When counter==1, the edge writes the result to HI/LO and returns to IDLE.
- start while BUSY (any op): ignored. md_stall must prevent this; the bench checks that it is ignored.
- Arithmetic:
  - mult: signed 2·WIDTH product; hi=upper half, lo=lower half.
  - multu: same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - divu: unsigned.
- Divide by zero: lo = all ones, hi = a. No exception.
- Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- md_stall = md_use_d & (busy | (start & md_op<=3)). mthi/mtlo never cause a stall.
- hi/lo outputs are registered; no combinational path from a/b.

Test Plan:
- Reset: reset=0 asynchronously mid-cycle → hi=0, lo=0, busy=0 immediately. Release, idle 3 cycles → outputs unchanged.
- mult signed: start, op=0, a=32'hFFFFFFFE (-2), b=3 → busy=1 for 5 cycles. At the 5th edge, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, busy=0. Same operands with multu → hi=2, lo=32'hFFFFFFFA.
- div signed: op=2, a=-7, b=2 → after 10 busy cycles, lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). divu 7/2 → lo=3, hi=1.
- Boundaries:
  - div a=5, b=0 → lo=32'hFFFFFFFF, hi=5.
  - div a=32'h80000000, b=-1 → lo=32'h80000000, hi=0.
- Stall and ignore:
  - During busy, md_use_d=1 → md_stall=1 every busy cycle and 0 the cycle busy falls.
  - Same cycle as start of mult with md_use_d=1 → md_stall=1.
  - start op=5 (mtlo) while busy → lo unchanged until the mult result lands.
- mthi/mtlo and abort: idle start op=4, a=32'h1234 → hi=32'h1234 next edge, busy stays 0. Start div, then pull reset low after 4 cycles → busy=0 and hi=lo=0 at once; no late write after reset releases.
